audio_adc_rx: RTL and testbench

- Receives the codec's ADC serial stream (aud_bclk, aud_adc_lrck, aud_adc_dat) in I2S format and deserialises it into parallel stereo sample pairs in the clkin_50 domain.
- It is the capture-side counterpart to the DAC playback path. Its output feeds a small show-ahead FIFO with a valid/ready interface for the processor-side audio input logic.
- The codec is bus master: BCLK and LRCK are inputs, and the block never drives codec pins.

---
 rtl/audio_rx_pkg.sv | 23 ++
 rtl/stereo_fifo.sv | 72 +++++++
 rtl/audio_adc_rx.sv | 164 ++++++++++++++++
 tb/tb_audio_adc_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_rx_pkg.sv
// Shared types and constants for the codec audio receive path.
package audio_rx_pkg;

    // Capture state machine states
    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LEFT,
        RIGHT
    } rx_state_e;

    // LRCK level that marks the left channel slot
    localparam logic LRCK_LEFT = 1'b0;

    // Bit clocks between an LRCK change and the word MSB
    localparam int unsigned I2S_DELAY = 1;

    // Default build parameters
    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/stereo_fifo.sv
// Show-ahead FIFO for stereo sample pairs; the head word holds its last
// value while the FIFO is empty.
module stereo_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_push;
    logic             do_pop;

    assign empty     = (level_q == '0);
    assign full      = (level_q == (PTR_W + 1)'(DEPTH));
    assign level     = level_q;
    assign head_data = empty ? last_q : mem_q[rd_ptr_q];

    // Push/pop qualification, pointer wrap and level bookkeeping
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            last_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: synchronises the codec serial stream into clkin_50,
// deserialises left/right words and queues completed pairs in a FIFO.
module audio_adc_rx
    import audio_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                          clkin_50,
    input  logic                          rst_n,
    input  logic                          aud_bclk,
    input  logic                          aud_adc_lrck,
    input  logic                          aud_adc_dat,
    input  logic                          enable,
    output logic [DATA_WIDTH-1:0]         sample_left,
    output logic [DATA_WIDTH-1:0]         sample_right,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic [SYNC_STAGES-1:0]  bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0]  lrck_sync_q, lrck_sync_d;
    logic [SYNC_STAGES-1:0]  dat_sync_q, dat_sync_d;
    logic                    bclk_prev_q, bclk_prev_d;
    logic                    lrck_prev_q, lrck_prev_d;
    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   left_q, left_d;
    logic [2*DATA_WIDTH-1:0] pair_q, pair_d;
    logic                    push_q, push_d;
    logic                    ovf_q, ovf_d;

    logic                    bclk_s, lrck_s, dat_s;
    logic                    strobe, boundary;
    logic [DATA_WIDTH-1:0]   word;
    logic [2*DATA_WIDTH-1:0] head;
    logic                    fifo_full, fifo_empty, drop;

    assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];

    // Input synchronisers, bclk edge detect and LRCK boundary detect
    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], aud_bclk};
        lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], aud_adc_lrck};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], aud_adc_dat};
        bclk_prev_d = bclk_s;
        strobe      = bclk_s & ~bclk_prev_q;
        boundary    = strobe & (lrck_s != lrck_prev_q);
        lrck_prev_d = strobe ? lrck_s : lrck_prev_q;
        // Bits are shifted in at the LSB; left-justify so short slots zero-fill
        word        = shift_q << (CNT_W'(DATA_WIDTH) - bit_cnt_q);
    end

    // Framing state machine: next state, shift register and commits
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        left_d    = left_q;
        pair_d    = pair_q;
        push_d    = 1'b0;
        if (!enable) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = SYNC;
                SYNC: begin
                    if (boundary && (lrck_s == LRCK_LEFT)) begin
                        state_d   = LEFT;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                LEFT, RIGHT: begin
                    if (boundary) begin
                        if (state_q == LEFT) begin
                            left_d  = word;
                            state_d = RIGHT;
                        end else begin
                            pair_d  = {left_q, word};
                            push_d  = 1'b1;
                            state_d = LEFT;
                        end
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else if (strobe && (bit_cnt_q < CNT_W'(DATA_WIDTH))) begin
                        shift_d   = {shift_q[DATA_WIDTH-2:0], dat_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_comb begin
        drop  = push_q & fifo_full & ~sample_ready;
        ovf_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    end

    // Receive-path registers
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            dat_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_q      <= '0;
            pair_q      <= '0;
            push_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lrck_sync_q <= lrck_sync_d;
            dat_sync_q  <= dat_sync_d;
            bclk_prev_q <= bclk_prev_d;
            lrck_prev_q <= lrck_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            pair_q      <= pair_d;
            push_q      <= push_d;
            ovf_q       <= ovf_d;
        end
    end

    stereo_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clkin_50),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (pair_q),
        .pop       (sample_valid & sample_ready),
        .head_data (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sample_valid = ~fifo_empty;
    assign sample_left  = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign sample_right = head[DATA_WIDTH-1:0];
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Scoreboard bench for audio_adc_rx: an I2S stream is driven from the
// clkin_50 negedge, expected pairs are queued as frames are issued and a
// monitor compares every popped head against the queue.
`timescale 1ns/1ps
module tb_audio_adc_rx;

    logic        clk;
    logic        rst_n;
    logic        aud_bclk;
    logic        aud_adc_lrck;
    logic        aud_adc_dat;
    logic        enable;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        overflow_clr;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    logic [15:0] fl [7] = '{16'h1A01, 16'h2B02, 16'h3C03, 16'h4D04, 16'h5E05, 16'h6F06, 16'h7A07};
    logic [15:0] fr [7] = '{16'h8101, 16'h9202, 16'hA303, 16'hB404, 16'hC505, 16'hD606, 16'hE707};

    audio_adc_rx #(
        .DATA_WIDTH  (16),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clkin_50     (clk),
        .rst_n        (rst_n),
        .aud_bclk     (aud_bclk),
        .aud_adc_lrck (aud_adc_lrck),
        .aud_adc_dat  (aud_adc_dat),
        .enable       (enable),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bclk period (16 clk); mode 1/2 pulses overflow_clr/sample_ready
    // in the cycle where the pair committed by this rising edge is written.
    task automatic send_bit(input logic lr, input logic d, input int mode);
        aud_bclk     = 1'b0;
        aud_adc_lrck = lr;
        aud_adc_dat  = d;
        repeat (8) @(negedge clk);
        aud_bclk = 1'b1;
        if (mode != 0) begin
            repeat (3) @(negedge clk);
            if (mode == 1) overflow_clr = 1'b1;
            else           sample_ready = 1'b1;
            @(negedge clk);
            overflow_clr = 1'b0;
            sample_ready = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
    endtask

    // Slot: junk delay bit, nbits MSB-first, then ones up to total clocks
    task automatic send_slot(input logic lr, input logic [31:0] word, input int nbits,
                             input int total, input int mode);
        send_bit(lr, 1'b1, mode);
        for (int i = 0; i < total - 1; i++) begin
            if (i < nbits) send_bit(lr, word[nbits-1-i], 0);
            else           send_bit(lr, 1'b1, 0);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int nbits, input int total);
        send_slot(1'b0, {16'h0, l}, nbits, total, 0);
        send_slot(1'b1, {16'h0, r}, nbits, total, 0);
    endtask

    task automatic sync_slot();
        send_slot(1'b1, 32'h5555, 16, 6, 0);
    endtask

    // Boundary that completes the last frame, then a disable
    task automatic close_phase(input int mode);
        send_bit(1'b0, 1'b1, mode);
        repeat (3) send_bit(1'b0, 1'b0, 0);
        enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: compare each popped head with the scoreboard
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #5;
            if (rst_n && sample_valid && sample_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h%h expected none", sample_left, sample_right);
                end else begin
                    e = exp_q.pop_front();
                    if ({sample_left, sample_right} !== e) begin
                        errors++;
                        $display("FAIL sb_pair: got %h%h expected %h", sample_left, sample_right, e);
                    end
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_ready = 1'b0; overflow_clr = 1'b0;
        aud_bclk = 1'b0; aud_adc_lrck = 1'b1; aud_adc_dat = 1'b0;
        repeat (4) @(negedge clk);
        #5;
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_left", 32'(sample_left), 32'h0);
        check("rst_right", 32'(sample_right), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture, partial frame seen during SYNC must not appear
        enable = 1'b1;
        send_slot(1'b0, 32'hFFFF, 16, 10, 0);
        send_slot(1'b1, 32'h5555, 16, 32, 0);
        exp_q.push_back(32'hA5C3_1234);
        send_frame(16'hA5C3, 16'h1234, 16, 32);
        close_phase(0);
        @(negedge clk); #5;
        check("basic_valid", 32'(sample_valid), 32'h1);
        check("basic_left", 32'(sample_left), 32'hA5C3);
        check("basic_right", 32'(sample_right), 32'h1234);
        check("basic_level", 32'(fifo_level), 32'h1);
        @(negedge clk);
        sample_ready = 1'b1;
        repeat (4) @(negedge clk); #5;
        check("basic_drained", 32'(fifo_level), 32'h0);

        // Short slot, 12 data bits: zero-filled LSBs
        enable = 1'b1;
        sync_slot();
        exp_q.push_back(32'hABC0_1230);
        send_frame(16'h0ABC, 16'h0123, 12, 13);
        close_phase(0);
        repeat (4) @(negedge clk); #5;
        check("short_hold_left", 32'(sample_left), 32'hABC0);

        // Overflow: five frames into a depth-4 FIFO, then clear vs new drop
        @(negedge clk);
        sample_ready = 1'b0;
        enable = 1'b1;
        sync_slot();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) exp_q.push_back({fl[k], fr[k]});
            send_frame(fl[k], fr[k], 16, 32);
        end
        @(negedge clk); #5;
        check("ovf_level", 32'(fifo_level), 32'h4);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_head", 32'(sample_left), 32'(fl[0]));
        close_phase(1);
        @(negedge clk); #5;
        check("ovf_set_wins", 32'(overflow), 32'h1);
        check("ovf_level2", 32'(fifo_level), 32'h4);
        check("ovf_head_l", 32'(sample_left), 32'(fl[0]));
        check("ovf_head_r", 32'(sample_right), 32'(fr[0]));
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        #5;
        check("ovf_cleared", 32'(overflow), 32'h0);

        // Full FIFO with pop and push in the same cycle
        @(negedge clk);
        enable = 1'b1;
        sync_slot();
        exp_q.push_back({fl[6], fr[6]});
        send_frame(fl[6], fr[6], 16, 32);
        close_phase(2);
        @(negedge clk); #5;
        check("fullpop_level", 32'(fifo_level), 32'h4);
        check("fullpop_ovf", 32'(overflow), 32'h0);
        check("fullpop_head", 32'(sample_left), 32'(fl[1]));
        @(negedge clk);
        sample_ready = 1'b1;
        repeat (10) @(negedge clk); #5;
        check("fullpop_empty", 32'(fifo_level), 32'h0);
        check("fullpop_hold", 32'(sample_left), 32'(fl[6]));

        // Enable drop during the right slot of frame B
        @(negedge clk);
        enable = 1'b1;
        sync_slot();
        exp_q.push_back(32'h1111_2222);
        send_frame(16'h1111, 16'h2222, 16, 32);
        send_slot(1'b0, 32'h3333, 16, 32, 0);
        send_slot(1'b1, 32'h4444, 16, 10, 0);
        enable = 1'b0;
        repeat (2) send_bit(1'b1, 1'b1, 0);
        enable = 1'b1;
        repeat (20) send_bit(1'b1, 1'b0, 0);
        exp_q.push_back(32'h5555_6666);
        send_frame(16'h5555, 16'h6666, 16, 32);
        close_phase(0);
        repeat (4) @(negedge clk);

        // Reset with two pairs stored
        sample_ready = 1'b0;
        enable = 1'b1;
        sync_slot();
        send_frame(16'h7777, 16'h8888, 16, 32);
        send_frame(16'h9999, 16'hAAAA, 16, 32);
        close_phase(0);
        @(negedge clk); #5;
        check("prerst_level", 32'(fifo_level), 32'h2);
        check("prerst_left", 32'(sample_left), 32'h7777);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(sample_valid), 32'h0);
        check("arst_left", 32'(sample_left), 32'h0);
        check("arst_right", 32'(sample_right), 32'h0);
        check("arst_level", 32'(fifo_level), 32'h0);
        check("arst_ovf", 32'(overflow), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sample_ready = 1'b1;
        enable = 1'b1;
        sync_slot();
        exp_q.push_back(32'hBEEF_CAFE);
        send_frame(16'hBEEF, 16'hCAFE, 16, 32);
        close_phase(0);

        repeat (10) @(negedge clk); #5;
        check("sb_all_seen", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
